serial_transfer_sequencer: RTL and testbench

- Parametrised successor to the fixed outward/inward transfer, S-erase and instruction gates.
- Adds a beat sequencer (IDLE/SCAN/ACTION/HALT) and a digit counter over a WORD_BITS serial word.
- During SCAN it staticises the instruction arriving serially from the main store. During ACTION it opens the outward gate, or the inward gate plus S-erase, according to the decoded function.
- Sits between the main store serial output, the accumulator serial output and the store write path.

---
 rtl/serial_transfer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_serial_transfer_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_transfer_sequencer.sv
// Beat sequencer and serial transfer gates between main store, accumulator
// and the store write path.
//
// Ports:
//   w_CLK, w_RST        clock, synchronous active-high reset
//   w_RUN               run request; a stop takes effect at the ACTION word boundary
//   w_MS_DATA_OUT       serial main store digit, LSB first
//   w_ACC_DATA_OUT      serial accumulator digit, LSB first
//   w_IG_INHIBIT        forces the captured instruction digit to 0
//   w_KLC               inhibits store writes (ITG and S-erase only)
//   w_OTG_DATA_OUT      store digit gated toward the accumulator
//   w_ITG_DATA_OUT      accumulator digit gated toward the store
//   w_S_ERASE_WF        store line erase waveform
//   w_BIT_NUM           current digit number within the word
//   w_BEAT              0 IDLE, 1 SCAN, 2 ACTION, 3 HALT
//   w_FUNC, w_ADDR      staticised instruction fields
//   w_HALTED            high in HALT
module serial_transfer_sequencer #(
    parameter int WORD_BITS = 32,
    parameter int ADDR_BITS = 5,
    parameter int ADDR_LSB  = 0,
    parameter int FUNC_BITS = 3,
    parameter int FUNC_LSB  = 13,
    localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
    input  logic                 w_CLK,
    input  logic                 w_RST,
    input  logic                 w_RUN,
    input  logic                 w_MS_DATA_OUT,
    input  logic                 w_ACC_DATA_OUT,
    input  logic                 w_IG_INHIBIT,
    input  logic                 w_KLC,
    output logic                 w_OTG_DATA_OUT,
    output logic                 w_ITG_DATA_OUT,
    output logic                 w_S_ERASE_WF,
    output logic [CNT_W-1:0]     w_BIT_NUM,
    output logic [1:0]           w_BEAT,
    output logic [FUNC_BITS-1:0] w_FUNC,
    output logic [ADDR_BITS-1:0] w_ADDR,
    output logic                 w_HALTED
);

    typedef enum logic [1:0] {
        BEAT_IDLE   = 2'd0,
        BEAT_SCAN   = 2'd1,
        BEAT_ACTION = 2'd2,
        BEAT_HALT   = 2'd3
    } beat_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

    localparam logic [FUNC_BITS-1:0] F_LDN  = FUNC_BITS'(2);
    localparam logic [FUNC_BITS-1:0] F_STO  = FUNC_BITS'(3);
    localparam logic [FUNC_BITS-1:0] F_SUB4 = FUNC_BITS'(4);
    localparam logic [FUNC_BITS-1:0] F_SUB5 = FUNC_BITS'(5);
    localparam logic [FUNC_BITS-1:0] F_STP  = FUNC_BITS'(7);

    beat_t                beat_q, beat_d;
    logic [CNT_W-1:0]     bit_q, bit_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic [FUNC_BITS-1:0] func_q, func_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 halted_q, halted_d;

    logic                 scan_din;
    logic                 last_bit;
    logic [WORD_BITS-1:0] scan_word;
    logic [CNT_W-1:0]     bit_next;

    assign scan_din  = w_MS_DATA_OUT & ~w_IG_INHIBIT;
    assign last_bit  = (bit_q == LAST_BIT);
    assign bit_next  = last_bit ? '0 : bit_q + 1'b1;
    // Word as it stands once the current digit is shifted in; at the last
    // digit this is the complete instruction.
    assign scan_word = {scan_din, shift_q[WORD_BITS-1:1]};

    always_comb begin
        beat_d   = beat_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        func_d   = func_q;
        addr_d   = addr_q;
        halted_d = halted_q;
        case (beat_q)
            BEAT_IDLE: begin
                if (w_RUN) begin
                    beat_d = BEAT_SCAN;
                end
            end
            BEAT_SCAN: begin
                shift_d = scan_word;
                bit_d   = bit_next;
                if (last_bit) begin
                    func_d = scan_word[FUNC_LSB +: FUNC_BITS];
                    addr_d = scan_word[ADDR_LSB +: ADDR_BITS];
                    beat_d = BEAT_ACTION;
                end
            end
            BEAT_ACTION: begin
                bit_d = bit_next;
                if (last_bit) begin
                    if (func_q == F_STP) begin
                        beat_d   = BEAT_HALT;
                        halted_d = 1'b1;
                    end else if (w_RUN) begin
                        beat_d = BEAT_SCAN;
                    end else begin
                        beat_d = BEAT_IDLE;
                    end
                end
            end
            default: begin
                bit_d = '0;
            end
        endcase
    end

    always_ff @(posedge w_CLK) begin
        if (w_RST) begin
            beat_q   <= BEAT_IDLE;
            bit_q    <= '0;
            shift_q  <= '0;
            func_q   <= '0;
            addr_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            func_q   <= func_d;
            addr_q   <= addr_d;
            halted_q <= halted_d;
        end
    end

    // Gates open only in ACTION; OTG and ITG decode from disjoint functions
    // so they can never be high together.
    always_comb begin
        w_OTG_DATA_OUT = 1'b0;
        w_ITG_DATA_OUT = 1'b0;
        w_S_ERASE_WF   = 1'b0;
        if (beat_q == BEAT_ACTION) begin
            case (func_q)
                F_LDN, F_SUB4, F_SUB5: begin
                    w_OTG_DATA_OUT = w_MS_DATA_OUT;
                end
                F_STO: begin
                    w_S_ERASE_WF   = ~w_KLC;
                    w_ITG_DATA_OUT = w_ACC_DATA_OUT & ~w_KLC;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_BIT_NUM = bit_q;
    assign w_BEAT    = beat_q;
    assign w_FUNC    = func_q;
    assign w_ADDR    = addr_q;
    assign w_HALTED  = halted_q;

endmodule

// File: tb/tb_serial_transfer_sequencer.sv
// Scoreboard bench for serial_transfer_sequencer: stimulus pushes the
// expected per-cycle outputs, a negedge monitor pops and compares.
module tb_serial_transfer_sequencer;

    typedef struct packed {
        logic       d40;
        logic [1:0] beat;
        logic [5:0] bitn;
        logic [2:0] func;
        logic [4:0] addr;
        logic       otg;
        logic       itg;
        logic       se;
        logic       halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic ms = 1'b0;
    logic acc = 1'b0;
    logic ig = 1'b0;
    logic klc = 1'b0;
    logic rst40 = 1'b1;
    logic run40 = 1'b0;
    logic ms40 = 1'b0;

    logic       otg32, itg32, se32, halt32;
    logic [4:0] bit32;
    logic [1:0] beat32;
    logic [2:0] func32;
    logic [4:0] addr32;

    logic       otg40, itg40, se40, halt40;
    logic [5:0] bit40;
    logic [1:0] beat40;
    logic [2:0] func40;
    logic [4:0] addr40;

    exp_t  q[$];
    string nq[$];
    int    checks = 0;
    int    errors = 0;

    logic [2:0] cur_f = 3'd0;
    logic [4:0] cur_a = 5'd0;

    always #5 clk = ~clk;

    serial_transfer_sequencer u_dut (
        .w_CLK          (clk),
        .w_RST          (rst),
        .w_RUN          (run),
        .w_MS_DATA_OUT  (ms),
        .w_ACC_DATA_OUT (acc),
        .w_IG_INHIBIT   (ig),
        .w_KLC          (klc),
        .w_OTG_DATA_OUT (otg32),
        .w_ITG_DATA_OUT (itg32),
        .w_S_ERASE_WF   (se32),
        .w_BIT_NUM      (bit32),
        .w_BEAT         (beat32),
        .w_FUNC         (func32),
        .w_ADDR         (addr32),
        .w_HALTED       (halt32)
    );

    serial_transfer_sequencer #(.WORD_BITS(40)) u_dut40 (
        .w_CLK          (clk),
        .w_RST          (rst40),
        .w_RUN          (run40),
        .w_MS_DATA_OUT  (ms40),
        .w_ACC_DATA_OUT (acc),
        .w_IG_INHIBIT   (ig),
        .w_KLC          (klc),
        .w_OTG_DATA_OUT (otg40),
        .w_ITG_DATA_OUT (itg40),
        .w_S_ERASE_WF   (se40),
        .w_BIT_NUM      (bit40),
        .w_BEAT         (beat40),
        .w_FUNC         (func40),
        .w_ADDR         (addr40),
        .w_HALTED       (halt40)
    );

    // Monitor: one expected record per checked cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = q.pop_front();
            n = nq.pop_front();
            a.d40 = e.d40;
            if (e.d40) begin
                a.beat = beat40; a.bitn = bit40; a.func = func40;
                a.addr = addr40; a.otg = otg40; a.itg = itg40;
                a.se = se40; a.halt = halt40;
            end else begin
                a.beat = beat32; a.bitn = {1'b0, bit32}; a.func = func32;
                a.addr = addr32; a.otg = otg32; a.itg = itg32;
                a.se = se32; a.halt = halt32;
            end
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s t=%0t got beat=%0d bit=%0d func=%0d addr=%0d otg=%b itg=%b se=%b halt=%b exp beat=%0d bit=%0d func=%0d addr=%0d otg=%b itg=%b se=%b halt=%b",
                         n, $time, a.beat, a.bitn, a.func, a.addr, a.otg, a.itg, a.se, a.halt,
                         e.beat, e.bitn, e.func, e.addr, e.otg, e.itg, e.se, e.halt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string n, input logic [1:0] b, input int bn,
                        input logic [2:0] f, input logic [4:0] a,
                        input logic o, input logic i, input logic s,
                        input logic h, input logic d40);
        exp_t e;
        e.d40 = d40; e.beat = b; e.bitn = 6'(bn); e.func = f; e.addr = a;
        e.otg = o; e.itg = i; e.se = s; e.halt = h;
        q.push_back(e);
        nq.push_back(n);
    endtask

    task automatic idle_start(input string n);
        tick();
        rst = 0; run = 1; ms = 0; acc = 0; ig = 0; klc = 0;
        push(n, 2'd0, 0, cur_f, cur_a, 0, 0, 0, 0, 0);
    endtask

    task automatic do_scan(input logic [31:0] w, input logic igv,
                           input int drop_at, input string n);
        for (int i = 0; i < 32; i++) begin
            tick();
            rst = 0; run = (i < drop_at); ms = w[i]; ig = igv;
            acc = 0; klc = 0;
            push(n, 2'd1, i, cur_f, cur_a, 0, 0, 0, 0, 0);
        end
        cur_f = igv ? 3'd0 : w[15:13];
        cur_a = igv ? 5'd0 : w[4:0];
    endtask

    task automatic do_action(input logic [31:0] msp, input logic [31:0] accp,
                             input logic k, input logic r, input int rst_at,
                             input string n);
        logic o, st;
        for (int i = 0; i < 32; i++) begin
            tick();
            ms = msp[i]; acc = accp[i]; klc = k; run = r; ig = 0;
            rst = (i == rst_at);
            o  = (cur_f == 3'd2 || cur_f == 3'd4 || cur_f == 3'd5) ? msp[i] : 1'b0;
            st = (cur_f == 3'd3);
            push(n, 2'd2, i, cur_f, cur_a, o, st & accp[i] & ~k, st & ~k, 0, 0);
            if (i == rst_at) break;
        end
    endtask

    initial begin
        // Reset state
        tick();
        rst = 1;
        tick();
        rst = 0; run = 0;
        push("reset_state", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0);
        tick();
        push("idle_hold", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0);

        // LDN addr 19, then STO twice and SUB back to back
        idle_start("ldn_start");
        do_scan(32'h5A5A_4013, 0, 99, "ldn_scan");
        do_action(32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 1, 99, "ldn_action");
        do_scan(32'h8000_6007, 0, 99, "sto_scan");
        do_action(32'h1234_5678, 32'h0000_FFFF, 0, 1, 99, "sto_action");
        do_scan(32'h0000_6007, 0, 99, "sto_klc_scan");
        do_action(32'h1234_5678, 32'h0000_FFFF, 1, 1, 99, "sto_klc_action");
        do_scan(32'hFFFF_8009, 0, 99, "sub_scan");
        do_action(32'h0F0F_00FF, 32'hFFFF_FFFF, 0, 0, 99, "sub_action");
        tick();
        run = 0;
        push("idle_after_sub", 2'd0, 0, 3'd4, 5'd9, 0, 0, 0, 0, 0);

        // Run dropped at SCAN bit 10 still completes the pair
        idle_start("drop_start");
        do_scan(32'h0000_4003, 0, 10, "drop_scan");
        do_action(32'hFFFF_FFFF, 32'h0, 0, 0, 99, "drop_action");
        tick();
        push("drop_idle", 2'd0, 0, 3'd2, 5'd3, 0, 0, 0, 0, 0);

        // Instruction gate inhibit yields JMP at address 0
        idle_start("ig_start");
        do_scan(32'hFFFF_A01F, 1, 99, "ig_scan");
        do_action(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 99, "ig_action");
        tick();
        push("ig_idle", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0);

        // Reset at ACTION bit 17
        idle_start("rst_start");
        do_scan(32'h0000_4001, 0, 99, "rst_scan");
        do_action(32'hFFFF_0000, 32'h0, 0, 1, 17, "rst_action");
        tick();
        rst = 0; run = 0;
        cur_f = 3'd0; cur_a = 5'd0;
        push("mid_action_reset", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0);

        // STP halts; run ignored until reset
        idle_start("stp_start");
        do_scan(32'h0000_E002, 0, 99, "stp_scan");
        do_action(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 99, "stp_action");
        for (int k = 0; k < 100; k++) begin
            tick();
            run = k[0]; ms = 1; acc = 1; klc = 0;
            push("halt_hold", 2'd3, 0, 3'd7, 5'd2, 0, 0, 0, 1, 0);
        end
        tick();
        rst = 1;
        push("halt_pre_reset", 2'd3, 0, 3'd7, 5'd2, 0, 0, 0, 1, 0);
        tick();
        rst = 0; run = 0;
        push("halt_reset", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 0);

        // 40-digit word: two back-to-back instructions, 80 cycles each
        tick();
        rst40 = 0; run40 = 1;
        push("w40_idle", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 160; k++) begin
            tick();
            run40 = (k < 150);
            push("w40_b2b", ((k / 40) % 2 == 1) ? 2'd2 : 2'd1, k % 40,
                 3'd0, 5'd0, 0, 0, 0, 0, 1);
        end
        tick();
        push("w40_end_idle", 2'd0, 0, 3'd0, 5'd0, 0, 0, 0, 0, 1);

        repeat (3) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
